// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer for single-ported data memory.
// Define DMEM_ARB_RR_EN for round-robin ties; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [2:0]    m0_mem_type,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [2:0]    m1_mem_type,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic [2:0]    mem_type,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t        state_q, state_d;
  logic          owner_q, owner_d, we_q, we_d, sel, rv;
  logic [2:0]    type_q, type_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [1:0]    cnt_q, cnt_d;
`ifdef DMEM_ARB_RR_EN
  logic last_q, last_d;
  assign sel = (m0_req && m1_req) ? !last_q : m1_req;
  assign last_d = (state_q == IDLE && (m0_req || m1_req)) ? sel : last_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= 1'b1;
    else last_q <= last_d;
`else
  assign sel = m1_req && !m0_req;
`endif
  // grants are combinational in IDLE and suppressed while reset is held
  assign m0_gnt = state_q == IDLE && !rst && m0_req && !sel;
  assign m1_gnt = state_q == IDLE && !rst && m1_req && sel;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    type_d  = type_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (m0_req || m1_req) begin
        state_d = ISSUE;
        owner_d = sel;
        we_d    = sel ? m1_we : m0_we;
        type_d  = sel ? m1_mem_type : m0_mem_type;
        addr_d  = sel ? m1_addr : m0_addr;
        wdata_d = sel ? m1_wdata : m0_wdata;
      end
      ISSUE: begin
        state_d = we_q ? IDLE : WAIT;
        cnt_d   = 2'(MEM_LAT - 1);
      end
      WAIT: begin
        cnt_d   = cnt_q - 2'd1;
        state_d = cnt_q == 2'd0 ? IDLE : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      type_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  assign rv        = state_q == WAIT && cnt_q == 2'd0;
  assign m0_rvalid = rv && !owner_q;
  assign m1_rvalid = rv && owner_q;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;
  assign mem_rd_en = state_q == ISSUE && !we_q;
  assign mem_wr_en = state_q == ISSUE && we_q;
  assign mem_type  = type_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = state_q != IDLE;
endmodule
